// File: rtl/optimsoc_tile_config_pkg.sv
// Shared definitions for the tile configuration slave: register map, feature bits,
// configuration structs and the elaboration-time config derivation.
package optimsoc_tile_config_pkg;

  localparam logic [31:0] VERSION = 32'h0000_0001;

  localparam logic [15:0] REG_VERSION         = 16'h0000;
  localparam logic [15:0] REG_TILEID          = 16'h0004;
  localparam logic [15:0] REG_NUMTILES        = 16'h0008;
  localparam logic [15:0] REG_CORES_PER_TILE  = 16'h000C;
  localparam logic [15:0] REG_TOTAL_NUM_CORES = 16'h0010;
  localparam logic [15:0] REG_COREBASE        = 16'h0014;
  localparam logic [15:0] REG_LMEM_SIZE       = 16'h0018;
  localparam logic [15:0] REG_FEATURES        = 16'h001C;
  localparam logic [15:0] REG_NUMCTS          = 16'h0020;
  localparam logic [15:0] REG_GMEM_SIZE       = 16'h0024;
  localparam logic [15:0] REG_GMEM_TILE       = 16'h0028;
  localparam logic [15:0] REG_SCRATCH         = 16'h002C;
  localparam logic [15:0] REG_NA_DMA_ENTRIES  = 16'h0030;

  localparam logic [15:0] CTLIST_BASE    = 16'h0200;
  localparam int          CTLIST_ENTRIES = 64;

  localparam int FEAT_NA_ENABLE_DMA      = 0;
  localparam int FEAT_NA_ENABLE_MPSIMPLE = 1;
  localparam int FEAT_ENABLE_BOOTROM     = 2;
  localparam int FEAT_ENABLE_DM          = 3;
  localparam int FEAT_ENABLE_PGAS        = 4;
  localparam int FEAT_USE_DEBUG          = 5;

  localparam logic [2:0] CTI_INCR = 3'b010;
  localparam logic [2:0] CTI_END  = 3'b111;

  typedef enum logic [1:0] {IDLE, RESP, BURST} state_t;

  typedef struct packed {
    logic [15:0]                          numtiles;
    logic [15:0]                          cores_per_tile;
    logic [31:0]                          lmem_size;
    logic [31:0]                          gmem_size;
    logic [31:0]                          gmem_tile;
    logic [15:0]                          numcts;
    logic [CTLIST_ENTRIES-1:0][15:0]      ctlist;
    logic [15:0]                          na_dma_entries;
    logic                                 na_enable_dma;
    logic                                 na_enable_mpsimple;
    logic                                 enable_bootrom;
    logic                                 enable_dm;
    logic                                 enable_pgas;
    logic                                 use_debug;
  } base_config_t;

  typedef struct packed {
    base_config_t base;
    logic [31:0]  total_num_cores;
  } config_t;

  function automatic base_config_t default_base_config();
    base_config_t b;
    b                = '0;
    b.numtiles       = 16'd1;
    b.cores_per_tile = 16'd1;
    b.lmem_size      = 32'h0000_8000;
    b.numcts         = 16'd1;
    b.na_enable_dma  = 1'b1;
    return b;
  endfunction

  function automatic config_t derive_config(input base_config_t b);
    config_t c;
    c.base            = b;
    c.total_num_cores = 32'(b.numtiles) * 32'(b.cores_per_tile);
    return c;
  endfunction

endpackage

// File: rtl/tile_config_regmux.sv
// Combinational register decode: maps a byte address onto the configuration
// constants and the scratch register, flagging mapped and writable locations.
module tile_config_regmux
  import optimsoc_tile_config_pkg::*;
#(
  parameter config_t CONFIG   = derive_config(default_base_config()),
  parameter int      TILEID   = 0,
  parameter int      COREBASE = 0
) (
  input  logic [15:0] adr,
  input  logic [31:0] scratch,
  output logic [31:0] rdata,
  output logic        valid,
  output logic        writable
);

  logic [15:0] word_adr;
  logic [5:0]  ct_idx;
  logic [31:0] features;
  logic        unused_adr;

  assign word_adr   = {adr[15:2], 2'b00};
  assign ct_idx     = adr[7:2];
  assign unused_adr = ^adr[1:0];

  always_comb begin
    features                          = '0;
    features[FEAT_NA_ENABLE_DMA]      = CONFIG.base.na_enable_dma;
    features[FEAT_NA_ENABLE_MPSIMPLE] = CONFIG.base.na_enable_mpsimple;
    features[FEAT_ENABLE_BOOTROM]     = CONFIG.base.enable_bootrom;
    features[FEAT_ENABLE_DM]          = CONFIG.base.enable_dm;
    features[FEAT_ENABLE_PGAS]        = CONFIG.base.enable_pgas;
    features[FEAT_USE_DEBUG]          = CONFIG.base.use_debug;
  end

  always_comb begin
    rdata    = '0;
    valid    = 1'b0;
    writable = 1'b0;
    // The whole 0x200-0x2FF window is mapped; entries past NUMCTS read as zero.
    if (word_adr[15:8] == CTLIST_BASE[15:8]) begin
      valid = 1'b1;
      if ({10'b0, ct_idx} < CONFIG.base.numcts) begin
        rdata = {16'h0, CONFIG.base.ctlist[ct_idx]};
      end
    end else begin
      valid = 1'b1;
      case (word_adr)
        REG_VERSION:         rdata = VERSION;
        REG_TILEID:          rdata = 32'(TILEID);
        REG_NUMTILES:        rdata = {16'h0, CONFIG.base.numtiles};
        REG_CORES_PER_TILE:  rdata = {16'h0, CONFIG.base.cores_per_tile};
        REG_TOTAL_NUM_CORES: rdata = CONFIG.total_num_cores;
        REG_COREBASE:        rdata = 32'(COREBASE);
        REG_LMEM_SIZE:       rdata = CONFIG.base.lmem_size;
        REG_FEATURES:        rdata = features;
        REG_NUMCTS:          rdata = {16'h0, CONFIG.base.numcts};
        REG_GMEM_SIZE:       rdata = CONFIG.base.gmem_size;
        REG_GMEM_TILE:       rdata = CONFIG.base.gmem_tile;
        REG_SCRATCH: begin
          rdata    = scratch;
          writable = 1'b1;
        end
        REG_NA_DMA_ENTRIES:  rdata = {16'h0, CONFIG.base.na_dma_entries};
        default:             valid = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/tile_config_slave.sv
// Wishbone B3 slave serving the tile configuration as read-only registers plus a
// scratch register. Define TILE_CONFIG_BURST_EN to enable incrementing read bursts.
module tile_config_slave
  import optimsoc_tile_config_pkg::*;
#(
  parameter config_t CONFIG   = derive_config(default_base_config()),
  parameter int      TILEID   = 0,
  parameter int      COREBASE = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_we_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic [2:0]  wb_cti_i,
  input  logic [1:0]  wb_bte_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        wb_err_o,
  output logic        wb_rty_o
);

  // Handshake: a request is cyc&stb seen in IDLE. The response (ack or err, never
  // both) is driven for one cycle from RESP while cyc stays high; the block then
  // returns to IDLE, so a held strobe starts its next access one cycle later.
  state_t      state, state_next;
  logic [15:0] adr_q, adr_next;
  logic [31:0] wdat_q;
  logic [3:0]  sel_q;
  logic        we_q;
  logic [31:0] scratch;
  logic [31:0] rdata;
  logic        valid, writable;
  logic        ack, err;
  logic        burst_advance;
  logic        scratch_wr;
  logic        req;

  assign req = wb_cyc_i & wb_stb_i;

  tile_config_regmux #(
    .CONFIG   (CONFIG),
    .TILEID   (TILEID),
    .COREBASE (COREBASE)
  ) u_regmux (
    .adr      (adr_q),
    .scratch  (scratch),
    .rdata    (rdata),
    .valid    (valid),
    .writable (writable)
  );

`ifdef TILE_CONFIG_BURST_EN
  logic [15:0] wrap_mask;
  logic [15:0] adr_inc;

  // Wrapping bursts only advance the address bits inside the window.
  always_comb begin
    case (wb_bte_i)
      2'b01:   wrap_mask = 16'h000F;
      2'b10:   wrap_mask = 16'h001F;
      2'b11:   wrap_mask = 16'h003F;
      default: wrap_mask = 16'h0000;
    endcase
    adr_inc  = adr_q + 16'd4;
    adr_next = (wrap_mask == 16'h0000) ? adr_inc
                                       : ((adr_q & ~wrap_mask) | (adr_inc & wrap_mask));
  end
`else
  logic unused_burst;
  assign unused_burst = ^{wb_cti_i, wb_bte_i};
  assign adr_next     = adr_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      adr_q   <= '0;
      wdat_q  <= '0;
      sel_q   <= '0;
      we_q    <= 1'b0;
      scratch <= '0;
    end else begin
      state <= state_next;
      if (state == IDLE && req) begin
        adr_q  <= wb_adr_i;
        wdat_q <= wb_dat_i;
        sel_q  <= wb_sel_i;
        we_q   <= wb_we_i;
      end else if (burst_advance) begin
        adr_q <= adr_next;
      end
      if (scratch_wr) begin
        for (int b = 0; b < 4; b++) begin
          if (sel_q[b]) scratch[8*b +: 8] <= wdat_q[8*b +: 8];
        end
      end
    end
  end

  always_comb begin
    state_next    = state;
    ack           = 1'b0;
    err           = 1'b0;
    burst_advance = 1'b0;
    scratch_wr    = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          state_next = RESP;
`ifdef TILE_CONFIG_BURST_EN
          if (!wb_we_i && wb_cti_i == CTI_INCR) state_next = BURST;
`endif
        end
      end
      RESP: begin
        state_next = IDLE;
        // A dropped cycle abandons the access, including any scratch update.
        if (wb_cyc_i) begin
          if (we_q) begin
            if (valid && writable) begin
              ack        = 1'b1;
              scratch_wr = 1'b1;
            end else begin
              err = 1'b1;
            end
          end else if (valid) begin
            ack = 1'b1;
          end else begin
            err = 1'b1;
          end
        end
      end
`ifdef TILE_CONFIG_BURST_EN
      BURST: begin
        if (!wb_cyc_i) begin
          state_next = IDLE;
        end else if (wb_stb_i) begin
          if (valid) begin
            ack = 1'b1;
            if (wb_cti_i == CTI_END) state_next = IDLE;
            else burst_advance = 1'b1;
          end else begin
            err        = 1'b1;
            state_next = IDLE;
          end
        end
      end
`endif
      default: state_next = IDLE;
    endcase
  end

  assign wb_ack_o = ack & ~rst;
  assign wb_err_o = err & ~rst;
  assign wb_dat_o = (ack & ~rst) ? rdata : 32'h0;
  assign wb_rty_o = 1'b0;

endmodule

// File: tb/tb_tile_config_slave.sv
// Self-checking bench for tile_config_slave: expected responses are queued when a
// request is driven and compared when the slave answers.
module tb_tile_config_slave;
  import optimsoc_tile_config_pkg::*;

  localparam int W = 33;

  function automatic base_config_t tb_base();
    base_config_t b;
    b                    = '0;
    b.numtiles           = 16'd4;
    b.cores_per_tile     = 16'd2;
    b.lmem_size          = 32'h0000_8000;
    b.gmem_size          = 32'h0010_0000;
    b.gmem_tile          = 32'd3;
    b.numcts             = 16'd2;
    b.ctlist[0]          = 16'd5;
    b.ctlist[1]          = 16'd9;
    b.ctlist[2]          = 16'd7;
    b.na_dma_entries     = 16'd4;
    b.na_enable_dma      = 1'b1;
    b.na_enable_mpsimple = 1'b0;
    b.enable_bootrom     = 1'b1;
    b.enable_dm          = 1'b0;
    b.enable_pgas        = 1'b1;
    b.use_debug          = 1'b1;
    return b;
  endfunction

  localparam config_t TB_CONFIG = derive_config(tb_base());

  logic        clk, rst;
  logic [15:0] wb_adr_i;
  logic [31:0] wb_dat_i;
  logic [3:0]  wb_sel_i;
  logic        wb_we_i, wb_cyc_i, wb_stb_i;
  logic [2:0]  wb_cti_i;
  logic [1:0]  wb_bte_i;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o, wb_err_o, wb_rty_o;

  logic [W-1:0] exp_q[$];
  logic [31:0]  scratch_model;
  int           n_checks = 0;
  int           n_pass   = 0;

  tile_config_slave #(
    .CONFIG   (TB_CONFIG),
    .TILEID   (3),
    .COREBASE (6)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .wb_adr_i (wb_adr_i),
    .wb_dat_i (wb_dat_i),
    .wb_sel_i (wb_sel_i),
    .wb_we_i  (wb_we_i),
    .wb_cyc_i (wb_cyc_i),
    .wb_stb_i (wb_stb_i),
    .wb_cti_i (wb_cti_i),
    .wb_bte_i (wb_bte_i),
    .wb_dat_o (wb_dat_o),
    .wb_ack_o (wb_ack_o),
    .wb_err_o (wb_err_o),
    .wb_rty_o (wb_rty_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    n_checks++;
    if (observed === expected) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
  endtask

  // Reference register map, written from the bench configuration above.
  function automatic logic [W-1:0] model_read(input logic [15:0] a);
    logic [15:0] w;
    w = {a[15:2], 2'b00};
    case (w)
      16'h0000: return {1'b0, 32'h0000_0001};
      16'h0004: return {1'b0, 32'd3};
      16'h0008: return {1'b0, 32'd4};
      16'h000C: return {1'b0, 32'd2};
      16'h0010: return {1'b0, 32'd8};
      16'h0014: return {1'b0, 32'd6};
      16'h0018: return {1'b0, 32'h0000_8000};
      16'h001C: return {1'b0, 32'h0000_0035};
      16'h0020: return {1'b0, 32'd2};
      16'h0024: return {1'b0, 32'h0010_0000};
      16'h0028: return {1'b0, 32'd3};
      16'h002C: return {1'b0, scratch_model};
      16'h0030: return {1'b0, 32'd4};
      16'h0200: return {1'b0, 32'd5};
      16'h0204: return {1'b0, 32'd9};
      default: begin
        if (w >= 16'h0208 && w <= 16'h02FC) return {1'b0, 32'h0};
        return {1'b1, 32'h0};
      end
    endcase
  endfunction

  // driver: one classic single access, response checked against the queue head
  task automatic bus_single(input string tag, input logic we, input logic [15:0] adr,
                            input logic [31:0] dat, input logic [3:0] sel, input logic [2:0] cti);
    int           waited;
    logic         got;
    logic [W-1:0] e;
    @(posedge clk); #1;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we;
    wb_adr_i = adr;  wb_dat_i = dat;  wb_sel_i = sel;
    wb_cti_i = cti;  wb_bte_i = 2'b00;
    @(negedge clk);
    check({tag, "_req_quiet"}, {wb_ack_o, wb_err_o}, 2'b00);
    waited = 0;
    got    = 1'b0;
    while (!got && waited < 4) begin
      @(negedge clk);
      waited++;
      if (wb_ack_o || wb_err_o) got = 1'b1;
    end
    if (exp_q.size() == 0) begin
      check({tag, "_sb_empty"}, 1, 0);
    end else begin
      e = exp_q.pop_front();
      if (!got) begin
        check({tag, "_timeout"}, 0, 1);
      end else begin
        check({tag, "_latency"}, waited, 1);
        check({tag, "_onehot"}, wb_ack_o ^ wb_err_o, 1'b1);
        check({tag, "_err"}, wb_err_o, e[32]);
        if (!we) check({tag, "_dat"}, wb_dat_o, e[31:0]);
      end
    end
    @(posedge clk); #1;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0; wb_cti_i = 3'b000;
    @(negedge clk);
    check({tag, "_post_quiet"}, {wb_ack_o, wb_err_o}, 2'b00);
  endtask

  task automatic rd(input string tag, input logic [15:0] adr);
    exp_q.push_back(model_read(adr));
    bus_single(tag, 1'b0, adr, 32'h0, 4'hF, 3'b000);
  endtask

  task automatic wr(input string tag, input logic [15:0] adr, input logic [31:0] dat,
                    input logic [3:0] sel, input logic exp_err);
    exp_q.push_back({exp_err, 32'h0});
    bus_single(tag, 1'b1, adr, dat, sel, 3'b000);
    if (!exp_err) begin
      for (int b = 0; b < 4; b++)
        if (sel[b]) scratch_model[8*b +: 8] = dat[8*b +: 8];
    end
  endtask

  initial begin
    logic [15:0]  a;
    logic [W-1:0] e;
    rst = 1'b1;
    wb_adr_i = '0; wb_dat_i = '0; wb_sel_i = '0; wb_we_i = 1'b0;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_cti_i = '0; wb_bte_i = '0;
    scratch_model = 32'h0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_outs", {wb_ack_o, wb_err_o, wb_rty_o, wb_dat_o}, 35'h0);

    rd("tileid", 16'h0004);
    rd("version", 16'h0000);
    for (int i = 2; i <= 12; i++) rd("regmap", 16'(4 * i));

    wr("scratch_wr", 16'h002C, 32'hDEAD_BEEF, 4'b0011, 1'b0);
    rd("scratch_rd", 16'h002C);
    wr("scratch_wr_hi", 16'h002C, 32'h1234_5678, 4'b1000, 1'b0);
    wr("scratch_wr_sel0", 16'h002C, 32'hFFFF_FFFF, 4'b0000, 1'b0);
    rd("scratch_rd2", 16'h002C);

    rd("ctlist0", 16'h0200);
    rd("ctlist1", 16'h0204);
    rd("ctlist2_beyond", 16'h0208);
    rd("ctlist63", 16'h02FC);

    wr("ro_write", 16'h0008, 32'h0000_0055, 4'hF, 1'b1);
    rd("ro_unchanged", 16'h0008);
    wr("ro_write_ver", 16'h0000, 32'hFFFF_FFFF, 4'hF, 1'b1);
    wr("unmapped_write", 16'h0100, 32'h1, 4'hF, 1'b1);
    rd("unmapped_100", 16'h0100);
    rd("unmapped_034", 16'h0034);
    rd("unmapped_300", 16'h0300);

    for (int i = 0; i < 24; i++) begin
      a = 16'(4 * $urandom_range(0, 13));
      if ($urandom_range(0, 3) == 0) a = 16'h0200 + 16'(4 * $urandom_range(0, 63));
      rd("rand_rd", a);
    end

    // reset in the cycle after a request drops the access
    @(posedge clk); #1;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = 16'h0004;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_resp", {wb_ack_o, wb_err_o}, 2'b00);
    @(posedge clk); #1;
    rst = 1'b0; wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    @(negedge clk);
    check("rst_mid_outs", {wb_ack_o, wb_err_o, wb_rty_o, wb_dat_o}, 35'h0);
    scratch_model = 32'h0;
    rd("scratch_after_rst", 16'h002C);

    // cyc dropped while the response is pending: no response, no write
    @(posedge clk); #1;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1; wb_adr_i = 16'h002C;
    wb_dat_i = 32'hFFFF_FFFF; wb_sel_i = 4'hF;
    @(posedge clk); #1;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    @(negedge clk);
    check("cyc_drop_quiet", {wb_ack_o, wb_err_o}, 2'b00);
    @(negedge clk);
    check("cyc_drop_quiet2", {wb_ack_o, wb_err_o}, 2'b00);
    rd("cyc_drop_scratch", 16'h002C);

`ifdef TILE_CONFIG_BURST_EN
    exp_q.push_back(model_read(16'h0008));
    exp_q.push_back(model_read(16'h000C));
    exp_q.push_back(model_read(16'h0000));
    exp_q.push_back(model_read(16'h0004));
    @(posedge clk); #1;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = 16'h0008;
    wb_cti_i = 3'b010; wb_bte_i = 2'b01;
    @(negedge clk);
    check("burst_req_quiet", {wb_ack_o, wb_err_o}, 2'b00);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      wb_cti_i = (k == 3) ? 3'b111 : 3'b010;
      @(negedge clk);
      check("burst_ack", {wb_ack_o, wb_err_o}, 2'b10);
      e = exp_q.pop_front();
      check("burst_dat", wb_dat_o, e[31:0]);
    end
    @(posedge clk); #1;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_cti_i = 3'b000; wb_bte_i = 2'b00;
    @(negedge clk);
    check("burst_end_quiet", {wb_ack_o, wb_err_o}, 2'b00);
    rd("after_burst", 16'h0014);
`else
    exp_q.push_back(model_read(16'h0008));
    bus_single("cti_ignored", 1'b0, 16'h0008, 32'h0, 4'hF, 3'b010);
`endif

    check("sb_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
